// File: rtl/cpu_pkg.sv
// Shared CPU definitions: address and instruction widths, reset PC and the fetch FSM state encoding.
package cpu_pkg;

  localparam int          ADDR_W   = 64;
  localparam int          INSTR_W  = 32;
  localparam logic [63:0] RESET_PC = 64'h0;

  typedef enum logic [1:0] {
    FETCH_REQ   = 2'd0,
    FETCH_WAIT  = 2'd1,
    FETCH_HOLD  = 2'd2,
    FETCH_DRAIN = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register: holds one fetched {PC, instruction} pair with load, clear and transfer control.
module ifid_reg
  import cpu_pkg::*;
#(
  parameter int ADDR_W = cpu_pkg::ADDR_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               clear,
  input  logic               xfer,
  input  logic [ADDR_W-1:0]  pc_in,
  input  logic [INSTR_W-1:0] instr_in,
  output logic               valid,
  output logic [ADDR_W-1:0]  pc,
  output logic [INSTR_W-1:0] instr
);

  // Clear beats load, and a load in the same cycle as a transfer keeps the register full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      pc    <= '0;
      instr <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      pc    <= pc_in;
      instr <= instr_in;
    end else if (xfer) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: one outstanding memory request, skid buffer for a stalled decode, flush redirect.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [63:0] RESET_PC = cpu_pkg::RESET_PC,
  parameter int          ADDR_W   = cpu_pkg::ADDR_W
) (
  input  logic               CLK,
  input  logic               resetl,
  input  logic [ADDR_W-1:0]  NextPC,
  input  logic               Flush,
  output logic [ADDR_W-1:0]  CurrentPC,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  output logic               IFID_valid,
  input  logic               IFID_ready,
  output logic [ADDR_W-1:0]  IFID_PC,
  output logic [INSTR_W-1:0] IFID_Instr
);

  fetch_state_t       state, state_nxt;
  logic [ADDR_W-1:0]  pc, pc_nxt;
  logic [INSTR_W-1:0] skid, skid_nxt;
  logic               ifid_load, ifid_from_skid;
  logic               ifid_free, ifid_xfer;
  logic [INSTR_W-1:0] ifid_instr_in;

  assign ifid_xfer      = IFID_valid && IFID_ready;
  assign ifid_free      = !IFID_valid || IFID_ready;
  assign ifid_instr_in  = ifid_from_skid ? skid : imem_rsp_data;

  // Gating with resetl keeps the request low while reset is held even though state already reads REQ.
  assign imem_req_valid = resetl && (state == FETCH_REQ);
  assign imem_addr      = pc;
  assign CurrentPC      = pc;

  always_comb begin
    state_nxt      = state;
    pc_nxt         = pc;
    skid_nxt       = skid;
    ifid_load      = 1'b0;
    ifid_from_skid = 1'b0;
    if (Flush) begin
      // A request accepted this cycle, or one still waiting, leaves a response that must be drained.
      pc_nxt   = NextPC;
      skid_nxt = '0;
      unique case (state)
        FETCH_REQ:   state_nxt = imem_req_ready ? FETCH_DRAIN : FETCH_REQ;
        FETCH_WAIT:  state_nxt = imem_rsp_valid ? FETCH_REQ : FETCH_DRAIN;
        FETCH_HOLD:  state_nxt = FETCH_REQ;
        FETCH_DRAIN: state_nxt = imem_rsp_valid ? FETCH_REQ : FETCH_DRAIN;
        default:     state_nxt = FETCH_REQ;
      endcase
    end else begin
      unique case (state)
        FETCH_REQ: begin
          if (imem_req_ready) state_nxt = FETCH_WAIT;
        end
        FETCH_WAIT: begin
          if (imem_rsp_valid && ifid_free) begin
            ifid_load = 1'b1;
            pc_nxt    = NextPC;
            state_nxt = FETCH_REQ;
          end else if (imem_rsp_valid) begin
            skid_nxt  = imem_rsp_data;
            state_nxt = FETCH_HOLD;
          end
        end
        FETCH_HOLD: begin
          if (ifid_free) begin
            ifid_load      = 1'b1;
            ifid_from_skid = 1'b1;
            pc_nxt         = NextPC;
            state_nxt      = FETCH_REQ;
          end
        end
        FETCH_DRAIN: begin
          if (imem_rsp_valid) state_nxt = FETCH_REQ;
        end
        default: state_nxt = FETCH_REQ;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      state <= FETCH_REQ;
      pc    <= RESET_PC[ADDR_W-1:0];
      skid  <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      skid  <= skid_nxt;
    end
  end

  ifid_reg #(
    .ADDR_W (ADDR_W)
  ) u_ifid (
    .clk      (CLK),
    .rst_n    (resetl),
    .load     (ifid_load),
    .clear    (Flush),
    .xfer     (ifid_xfer),
    .pc_in    (pc),
    .instr_in (ifid_instr_in),
    .valid    (IFID_valid),
    .pc       (IFID_PC),
    .instr    (IFID_Instr)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed vector bench for fetch_stage: per-cycle memory/decode stimulus with hand-computed outputs.
module tb_fetch_stage;

  logic        CLK;
  logic        resetl;
  logic [63:0] NextPC;
  logic        Flush;
  logic [63:0] CurrentPC;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        IFID_valid;
  logic        IFID_ready;
  logic [63:0] IFID_PC;
  logic [31:0] IFID_Instr;

  logic        redir;
  logic [63:0] tgt;
  int          compared;
  int          mismatched;

  typedef struct packed {
    logic        rr;
    logic        rv;
    logic [31:0] rd;
    logic        ir;
    logic        fl;
    logic [63:0] tgt;
    logic        e_rv;
    logic [63:0] e_addr;
    logic        e_iv;
    logic [63:0] e_ipc;
    logic [31:0] e_instr;
  } vec_t;

  localparam int NVEC = 29;
  vec_t vecs [NVEC];

  // Upstream next-PC logic: sequential +4 unless a redirect target is presented with Flush.
  assign NextPC = redir ? tgt : CurrentPC + 64'd4;

  fetch_stage #(
    .RESET_PC (64'h0),
    .ADDR_W   (64)
  ) dut (
    .CLK            (CLK),
    .resetl         (resetl),
    .NextPC         (NextPC),
    .Flush          (Flush),
    .CurrentPC      (CurrentPC),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .IFID_valid     (IFID_valid),
    .IFID_ready     (IFID_ready),
    .IFID_PC        (IFID_PC),
    .IFID_Instr     (IFID_Instr)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [31:0] instr_of(input logic [63:0] a);
    return 32'h1300_0000 + a[31:0];
  endfunction

  function automatic vec_t mk(input logic rr, input logic rv, input logic [63:0] rsp_addr,
                              input logic ir, input logic fl, input logic [63:0] t,
                              input logic e_rv, input logic [63:0] e_addr,
                              input logic e_iv, input logic [63:0] e_ipc);
    vec_t v;
    v.rr      = rr;
    v.rv      = rv;
    v.rd      = rv ? instr_of(rsp_addr) : 32'h0;
    v.ir      = ir;
    v.fl      = fl;
    v.tgt     = t;
    v.e_rv    = e_rv;
    v.e_addr  = e_addr;
    v.e_iv    = e_iv;
    v.e_ipc   = e_ipc;
    v.e_instr = instr_of(e_ipc);
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    imem_req_ready = v.rr;
    imem_rsp_valid = v.rv;
    imem_rsp_data  = v.rd;
    IFID_ready     = v.ir;
    Flush          = v.fl;
    redir          = v.fl;
    tgt            = v.tgt;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    IFID_ready     = 1'b0;
    Flush          = 1'b0;
    redir          = 1'b0;
    tgt            = 64'h0;
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, " req_valid"}, {63'h0, imem_req_valid}, 64'h0);
    checkOutput({tag, " CurrentPC"}, CurrentPC, 64'h0);
    checkOutput({tag, " imem_addr"}, imem_addr, 64'h0);
    checkOutput({tag, " IFID_valid"}, {63'h0, IFID_valid}, 64'h0);
    checkOutput({tag, " IFID_PC"}, IFID_PC, 64'h0);
    checkOutput({tag, " IFID_Instr"}, {32'h0, IFID_Instr}, 64'h0);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    resetl     = 1'b0;
    idle();

    // Vector k holds inputs for cycle k and the outputs expected before that cycle's rising edge.
    vecs[0]  = mk(1, 0, 0,       1, 0, 0,       1, 64'h0,   0, 0);
    vecs[1]  = mk(0, 1, 64'h0,   1, 0, 0,       0, 64'h0,   0, 0);
    vecs[2]  = mk(1, 0, 0,       1, 0, 0,       1, 64'h4,   1, 64'h0);
    vecs[3]  = mk(0, 1, 64'h4,   1, 0, 0,       0, 64'h4,   0, 0);
    vecs[4]  = mk(1, 0, 0,       0, 0, 0,       1, 64'h8,   1, 64'h4);
    vecs[5]  = mk(0, 1, 64'h8,   0, 0, 0,       0, 64'h8,   1, 64'h4);
    vecs[6]  = mk(0, 0, 0,       0, 0, 0,       0, 64'h8,   1, 64'h4);
    vecs[7]  = mk(0, 0, 0,       1, 0, 0,       0, 64'h8,   1, 64'h4);
    vecs[8]  = mk(0, 0, 0,       0, 0, 0,       1, 64'hC,   1, 64'h8);
    vecs[9]  = mk(0, 0, 0,       1, 0, 0,       1, 64'hC,   1, 64'h8);
    vecs[10] = mk(0, 0, 0,       0, 0, 0,       1, 64'hC,   0, 0);
    vecs[11] = mk(1, 0, 0,       0, 0, 0,       1, 64'hC,   0, 0);
    vecs[12] = mk(0, 1, 64'hC,   1, 0, 0,       0, 64'hC,   0, 0);
    vecs[13] = mk(1, 0, 0,       1, 0, 0,       1, 64'h10,  1, 64'hC);
    vecs[14] = mk(0, 0, 0,       1, 1, 64'h100, 0, 64'h10,  0, 0);
    vecs[15] = mk(0, 0, 0,       1, 0, 0,       0, 64'h100, 0, 0);
    vecs[16] = mk(0, 1, 64'h10,  1, 0, 0,       0, 64'h100, 0, 0);
    vecs[17] = mk(1, 0, 0,       1, 0, 0,       1, 64'h100, 0, 0);
    vecs[18] = mk(0, 1, 64'h100, 1, 0, 0,       0, 64'h100, 0, 0);
    vecs[19] = mk(1, 0, 0,       0, 0, 0,       1, 64'h104, 1, 64'h100);
    vecs[20] = mk(0, 1, 64'h104, 0, 1, 64'h200, 0, 64'h104, 1, 64'h100);
    vecs[21] = mk(0, 0, 0,       0, 0, 0,       1, 64'h200, 0, 0);
    vecs[22] = mk(1, 0, 0,       0, 1, 64'h300, 1, 64'h200, 0, 0);
    vecs[23] = mk(1, 0, 0,       0, 0, 0,       0, 64'h300, 0, 0);
    vecs[24] = mk(0, 1, 64'h200, 0, 0, 0,       0, 64'h300, 0, 0);
    vecs[25] = mk(1, 0, 0,       0, 0, 0,       1, 64'h300, 0, 0);
    vecs[26] = mk(0, 1, 64'h300, 1, 0, 0,       0, 64'h300, 0, 0);
    vecs[27] = mk(0, 0, 0,       0, 1, 64'h400, 1, 64'h304, 1, 64'h300);
    vecs[28] = mk(1, 0, 0,       0, 0, 0,       1, 64'h400, 0, 0);

    @(negedge CLK);
    #1;
    checkReset("por");
    repeat (2) @(negedge CLK);
    resetl = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i]);
      #1;
      checkOutput($sformatf("v%0d req_valid", i), {63'h0, imem_req_valid}, {63'h0, vecs[i].e_rv});
      checkOutput($sformatf("v%0d imem_addr", i), imem_addr, vecs[i].e_addr);
      checkOutput($sformatf("v%0d CurrentPC", i), CurrentPC, vecs[i].e_addr);
      checkOutput($sformatf("v%0d IFID_valid", i), {63'h0, IFID_valid}, {63'h0, vecs[i].e_iv});
      if (vecs[i].e_iv) begin
        checkOutput($sformatf("v%0d IFID_PC", i), IFID_PC, vecs[i].e_ipc);
        checkOutput($sformatf("v%0d IFID_Instr", i), {32'h0, IFID_Instr}, {32'h0, vecs[i].e_instr});
      end
      @(negedge CLK);
    end

    // Reset asserted while WAIT for 0x400 is outstanding; IF/ID still holds stale 0x300 contents.
    idle();
    resetl = 1'b0;
    #1;
    checkReset("midwait");
    @(negedge CLK);
    #1;
    checkReset("held");
    resetl         = 1'b1;
    imem_req_ready = 1'b1;
    #1;
    checkOutput("rel req_valid", {63'h0, imem_req_valid}, 64'h1);
    checkOutput("rel imem_addr", imem_addr, 64'h0);
    @(negedge CLK);
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = instr_of(64'h0);
    IFID_ready     = 1'b1;
    #1;
    checkOutput("rel wait req_valid", {63'h0, imem_req_valid}, 64'h0);
    @(negedge CLK);
    imem_rsp_valid = 1'b0;
    IFID_ready     = 1'b0;
    #1;
    checkOutput("rel IFID_valid", {63'h0, IFID_valid}, 64'h1);
    checkOutput("rel IFID_PC", IFID_PC, 64'h0);
    checkOutput("rel IFID_Instr", {32'h0, IFID_Instr}, {32'h0, instr_of(64'h0)});
    checkOutput("rel next addr", imem_addr, 64'h4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 64'h0, SHALL be the PC value loaded on reset.
REQ-002 Parameter ADDR_W, default 64, SHALL set the width of the PC and the memory address.
REQ-003 CLK  in  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 resetl  in  1  SHALL be the reset: asynchronous, active-low.
REQ-005 NextPC  in  64  SHALL be the next-PC value from the next-PC logic, computed from CurrentPC.
REQ-006 Flush  in  1  SHALL request a redirect: discard in-flight fetch, load NextPC.
REQ-007 CurrentPC  out  64  SHALL be the PC register value, fed to the next-PC logic.
REQ-008 imem_req_valid  out  1  SHALL be the instruction-memory request valid.
REQ-009 imem_req_ready  in  1  SHALL be the instruction-memory request accept.
REQ-010 imem_addr  out  64  SHALL be the request address; it equals CurrentPC.
REQ-011 imem_rsp_valid  in  1  SHALL be a one-cycle pulse marking the response.
REQ-012 imem_rsp_data  in  32  SHALL be the instruction word; valid only with imem_rsp_valid.
REQ-013 IFID_valid  out  1  SHALL mark IF/ID register contents as valid.
REQ-014 IFID_ready  in  1  SHALL be the decode-stage accept; transfer when IFID_valid && IFID_ready.
REQ-015 IFID_PC  out  64  SHALL be the PC of the instruction held in IF/ID.
REQ-016 IFID_Instr  out  32  SHALL be the instruction held in IF/ID.

Function
REQ-017 FSM states SHALL be REQ, WAIT, HOLD and DRAIN; at most one memory request SHALL be outstanding.
REQ-018 REQ: imem_req_valid=1; on imem_req_ready, go to WAIT; valid and addr SHALL stay stable until accepted.
REQ-019 WAIT: on imem_rsp_valid with IF/ID free (IFID_valid=0, or transfer this cycle), load IF/ID with {PC, data}, set IFID_valid, set PC<=NextPC, and go to REQ.
REQ-020 WAIT: on imem_rsp_valid with IF/ID occupied and no transfer, capture data in the skid register and go to HOLD.
REQ-021 HOLD: on the first cycle IF/ID is free, load IF/ID from skid with the current PC, set PC<=NextPC, and go to REQ.
REQ-022 IFID_valid SHALL clear on a transfer unless a new load occurs the same cycle.
REQ-023 Flush SHALL have priority over all other events; it sets PC<=NextPC and clears IFID_valid and the skid register.
REQ-024 Flush in REQ before acceptance: go to REQ with the new PC; in REQ with acceptance the same cycle: go to DRAIN.
REQ-025 Flush in WAIT without a response: go to DRAIN; in WAIT with a response the same cycle: discard it and go to REQ.
REQ-026 Flush in HOLD: go to REQ.
REQ-027 DRAIN: imem_req_valid=0; on imem_rsp_valid, discard the data and go to REQ; PC SHALL be unchanged.
REQ-028 The PC SHALL advance only as stated above, so no instruction is lost or duplicated; NextPC is taken unmodified (wrap is the upstream's concern).
REQ-029 Request-to-IF/ID latency SHALL be 1 cycle after imem_rsp_valid when IF/ID is free.

Reset
REQ-030 While resetl=0, immediately: PC=RESET_PC, state=REQ, IFID_valid=0, IFID_PC=0, IFID_Instr=0, skid cleared.
REQ-031 imem_req_valid SHALL be 0 during reset and SHALL assert in the first cycle after release.
REQ-032 Reset mid-fetch SHALL abandon the outstanding request; the memory is reset with the same resetl.

Structure
REQ-033 Shared package cpu_pkg SHALL hold: the fetch-state enum, ADDR_W, INSTR_W=32, and RESET_PC default.
REQ-034 The IF/ID register (valid/PC/Instr with load, clear and transfer) SHALL be sub-module ifid_reg.

Verification
REQ-035 Reset release, ready=1, 1-cycle response latency, NextPC=PC+4, IFID_ready=1 -> IFID_PC sequence 0, 4, 8, with correct instructions and no gaps beyond FSM latency.
REQ-036 imem_req_ready=0 for 3 cycles -> imem_req_valid=1 and imem_addr=0 held stable; PC unchanged until acceptance.
REQ-037 IFID_ready=0 while the response for PC=0x8 arrives -> HOLD entered; after IFID_ready=1, IFID_PC=0x8 is delivered, then 0xC, with no loss.
REQ-038 Flush with NextPC=0x100 while WAIT is pending for 0x10 -> 0x10 response discarded; next request address is 0x100; IFID_valid=0 in the interim.
REQ-039 Flush coincident with imem_rsp_valid -> data discarded, next imem_addr=NextPC, IFID_valid=0.
REQ-040 resetl low mid-WAIT -> all outputs at reset values asynchronously; after release, the first fetch is from RESET_PC.
